// File: rtl/task_0_pkg.sv
// Shared widths and types for the task_0 adder slice.
package task_0_pkg;

  localparam int W     = 4;
  localparam int CNT_W = 8;

  typedef logic [W-1:0]     operand_t;
  typedef logic [W:0]       sum_t;
  typedef logic [CNT_W-1:0] cnt_t;

  localparam cnt_t CNT_MAX = '1;

  // Saturating increment used by the carry-event counter.
  function automatic cnt_t sat_inc(input cnt_t value);
    if (value == CNT_MAX) begin
      return value;
    end
    return value + cnt_t'(1);
  endfunction

endpackage

// File: rtl/task_0_full_adder.sv
// One-bit full adder cell; chained W times to form the ripple-carry adder.
module task_0_full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/task_0.sv
// 4-bit ripple-carry adder with a combinational sum, a one-cycle registered
// shadow of the sum/carry and a saturating count of carry-out cycles.
module task_0
  import task_0_pkg::*;
(
  input  logic             i_w_clk,
  input  logic             i_w_rst_n,
  input  logic [W-1:0]     i_w_a,
  input  logic [W-1:0]     i_w_b,
  output logic [W:0]       o_w_s,
  output logic [W:0]       o_r_s,
  output logic             o_r_c,
  output logic [CNT_W-1:0] o_r_cnt
);

  logic [W:0]   carry;
  operand_t     sum_bits;

  sum_t         sum_d,   sum_q;
  logic         carry_d, carry_q;
  cnt_t         cnt_d,   cnt_q;

  assign carry[0] = 1'b0;

  for (genvar i = 0; i < W; i++) begin : g_ripple
    task_0_full_adder u_fa (
      .a    (i_w_a[i]),
      .b    (i_w_b[i]),
      .cin  (carry[i]),
      .s    (sum_bits[i]),
      .cout (carry[i+1])
    );
  end

  // Sum path stays live regardless of clock or reset.
  assign o_w_s = {carry[W], sum_bits};

  always_comb begin
    sum_d   = o_w_s;
    carry_d = o_w_s[W];
    cnt_d   = cnt_q;
    if (o_w_s[W]) begin
      cnt_d = sat_inc(cnt_q);
    end
  end

  always_ff @(posedge i_w_clk) begin
    if (!i_w_rst_n) begin
      sum_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
    end
  end

  assign o_r_s   = sum_q;
  assign o_r_c   = carry_q;
  assign o_r_cnt = cnt_q;

endmodule

// File: tb/tb_task_0.sv
// Self-checking bench for task_0: combinational sweep plus a scoreboard of
// expected registered outputs pushed at drive time and popped after each edge.
module tb_task_0;

  logic       clk;
  logic       rst_n;
  logic [3:0] a;
  logic [3:0] b;
  logic [4:0] w_s;
  logic [4:0] r_s;
  logic       r_c;
  logic [7:0] r_cnt;

  typedef struct packed {
    logic [4:0] s;
    logic       c;
    logic [7:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;
  int   model_cnt = 0;

  task_0 dut (
    .i_w_clk   (clk),
    .i_w_rst_n (rst_n),
    .i_w_a     (a),
    .i_w_b     (b),
    .o_w_s     (w_s),
    .o_r_s     (r_s),
    .o_r_c     (r_c),
    .o_r_cnt   (r_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkVal(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  // Drive one cycle of inputs at the falling edge and record the registered
  // outputs the DUT should show after the next rising edge.
  task automatic applyStimulus(input int av, input int bv, input logic rstv);
    exp_t e;
    int   sum;
    @(negedge clk);
    a     = 4'(av);
    b     = 4'(bv);
    rst_n = rstv;
    sum   = av + bv;
    if (!rstv) begin
      model_cnt = 0;
      e.s = 5'd0;
      e.c = 1'b0;
    end else begin
      if (sum >= 16 && model_cnt < 255) model_cnt++;
      e.s = 5'(sum);
      e.c = (sum >= 16);
    end
    e.cnt = 8'(model_cnt);
    exp_q.push_back(e);
    #1;
    checkVal("comb_during_step", 16'(w_s), 16'(sum));
  endtask

  task automatic checkOutput(input string tag);
    exp_t e;
    @(posedge clk);
    #1;
    checks++;
    assert (exp_q.size() != 0) else begin
      failures++;
      $error("[TB] FAIL %s_queue observed=empty expected=entry", tag);
    end
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      checkVal({tag, "_s"},   16'(r_s),   16'(e.s));
      checkVal({tag, "_c"},   16'(r_c),   16'(e.c));
      checkVal({tag, "_cnt"}, 16'(r_cnt), 16'(e.cnt));
    end
  endtask

  task automatic stepN(input int av, input int bv, input logic rstv, input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      applyStimulus(av, bv, rstv);
      checkOutput(tag);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    a = 4'd0;
    b = 4'd0;

    $display("[TB] exhaustive combinational sweep with reset held low");
    for (int ia = 0; ia < 16; ia++) begin
      for (int ib = 0; ib < 16; ib++) begin
        a = 4'(ia);
        b = 4'(ib);
        #5;
        checkVal("comb_sweep", 16'(w_s), 16'(ia + ib));
        #5;
      end
    end

    a = 4'd9;  b = 4'd7;  #5; checkVal("comb_9_7",   16'(w_s), 16'd16); #5;
    a = 4'd3;  b = 4'd4;  #5; checkVal("comb_3_4",   16'(w_s), 16'd7);  #5;
    a = 4'd0;  b = 4'd0;  #5; checkVal("comb_0_0",   16'(w_s), 16'd0);  #5;
    a = 4'd15; b = 4'd0;  #5; checkVal("comb_15_0",  16'(w_s), 16'd15); #5;
    a = 4'd15; b = 4'd1;  #5; checkVal("comb_15_1",  16'(w_s), 16'd16); #5;
    a = 4'd15; b = 4'd15; #5; checkVal("comb_15_15", 16'(w_s), 16'd30); #5;

    $display("[TB] reset with a=15 b=15");
    stepN(15, 15, 1'b0, 2, "reset_hold");

    $display("[TB] register latency");
    stepN(5, 6, 1'b1, 1, "latency");

    $display("[TB] carry counter");
    stepN(8, 8, 1'b1, 10, "carry_8_8");
    checkVal("cnt_after_10", 16'(r_cnt), 16'd10);
    stepN(1, 1, 1'b1, 5, "no_carry");
    checkVal("cnt_hold_10", 16'(r_cnt), 16'd10);

    $display("[TB] saturation and mid-run reset");
    stepN(15, 15, 1'b1, 300, "saturate");
    checkVal("cnt_saturated", 16'(r_cnt), 16'd255);
    stepN(15, 15, 1'b0, 1, "mid_reset");
    checkVal("cnt_after_reset", 16'(r_cnt), 16'd0);
    stepN(7, 9, 1'b1, 1, "post_release");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
